// File: rtl/inst_pair_fetch.sv
// Instruction pair fetch adapter: returns {mem[PC], mem[PC+4]} from a small
// fully-associative pair buffer, fetching both words from a one-word memory port on a miss.
module inst_pair_fetch #(
  parameter int          ENTRIES   = 2,
  parameter logic [31:0] RESET_TAG = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_flush,
  input  logic        cpu_invalidate,
  output logic [31:0] cpu_rdata,
  output logic [31:0] cpu_rdata_2,
  output logic        cpu_stall,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int VW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {IDLE, FETCH1, FETCH2, FILL} state_t;

  state_t          state;
  logic [29:0]     req_addr;
  logic [31:0]     word0;
  logic [31:0]     word1;
  logic            abort;
  logic [VW-1:0]   victim;

  logic [ENTRIES-1:0] valid;
  logic [29:0]        tag   [ENTRIES];
  logic [31:0]        data0 [ENTRIES];
  logic [31:0]        data1 [ENTRIES];
  logic [ENTRIES-1:0] match;

  logic [29:0] pc_tag;
  logic [1:0]  unused_lsb;
  logic        any_match;
  logic        hit;
  logic        do_fill;

  assign pc_tag     = cpu_addr[31:2];
  assign unused_lsb = cpu_addr[1:0];
  assign any_match  = |match;
  assign hit        = cpu_read && (state == IDLE) && any_match;
  assign cpu_stall  = cpu_read && !hit;
  // Invalidate and flush both win over the FILL write, as does an earlier abort.
  assign do_fill    = (state == FILL) && !abort && !cpu_invalidate && !cpu_flush;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign match[gi] = valid[gi] && (tag[gi] == pc_tag);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid[gi] <= 1'b0;
          tag[gi]   <= RESET_TAG[31:2];
          data0[gi] <= '0;
          data1[gi] <= '0;
        end else begin
          if (cpu_invalidate)
            valid[gi] <= 1'b0;
          else if (do_fill && (victim == VW'(gi)))
            valid[gi] <= 1'b1;
          if (do_fill && (victim == VW'(gi))) begin
            tag[gi]   <= req_addr;
            data0[gi] <= word0;
            data1[gi] <= word1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    cpu_rdata   = '0;
    cpu_rdata_2 = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (hit && match[i]) begin
        cpu_rdata   = cpu_rdata | data0[i];
        cpu_rdata_2 = cpu_rdata_2 | data1[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_addr <= '0;
      word0    <= '0;
      word1    <= '0;
      abort    <= 1'b0;
      victim   <= '0;
      mem_read <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_read && !any_match) begin
            req_addr <= pc_tag;
            mem_read <= 1'b1;
            mem_addr <= {pc_tag, 2'b00};
            state    <= FETCH1;
          end
        end
        FETCH1: begin
          if (cpu_flush || cpu_invalidate)
            abort <= 1'b1;
          if (mem_ready) begin
            word0    <= mem_rdata;
            mem_addr <= {req_addr + 30'd1, 2'b00};
            state    <= FETCH2;
          end
        end
        FETCH2: begin
          if (cpu_flush || cpu_invalidate)
            abort <= 1'b1;
          if (mem_ready) begin
            word1    <= mem_rdata;
            mem_read <= 1'b0;
            state    <= FILL;
          end
        end
        default: begin
          if (do_fill)
            victim <= (victim == VW'(ENTRIES - 1)) ? '0 : victim + VW'(1);
          abort <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_pair_fetch.sv
// Randomized bench for inst_pair_fetch: a transaction-level pair-buffer model predicts
// hit/miss, stall length, memory address stream and returned instruction pair.
module tb_inst_pair_fetch;
  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_read;
  logic [31:0] cpu_addr;
  logic        cpu_flush;
  logic        cpu_invalidate;
  logic [31:0] cpu_rdata;
  logic [31:0] cpu_rdata_2;
  logic        cpu_stall;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  inst_pair_fetch #(.ENTRIES(N), .RESET_TAG(32'hBFC00000)) dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_addr(cpu_addr),
    .cpu_flush(cpu_flush), .cpu_invalidate(cpu_invalidate),
    .cpu_rdata(cpu_rdata), .cpu_rdata_2(cpu_rdata_2), .cpu_stall(cpu_stall),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Memory responder: mem_ready after lat_cfg wait cycles per word.
  int          lat_cfg = 0;
  int          mem_cnt = 0;
  logic [31:0] hold_addr = '0;
  logic [31:0] got_q[$];

  always @(negedge clk) begin
    if (rst) begin
      mem_ready = 1'b0;
      mem_cnt   = 0;
    end else begin
      if (mem_ready) begin
        mem_ready = 1'b0;
        mem_cnt   = 0;
      end
      if (mem_read) begin
        if (mem_cnt == 0) hold_addr = mem_addr;
        else chk("mem_addr_stable", mem_addr, hold_addr);
        if (mem_cnt >= lat_cfg) begin
          mem_ready = 1'b1;
          mem_rdata = mem_word(mem_addr);
          got_q.push_back(mem_addr);
        end else begin
          mem_cnt++;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Reference model: buffered tags, round-robin replacement pointer.
  logic [29:0] m_tag[N];
  bit          m_val[N];
  int          m_ptr = 0;

  function automatic int m_find(input logic [29:0] t);
    for (int i = 0; i < N; i++) if (m_val[i] && m_tag[i] == t) return i;
    return -1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) m_val[i] = 1'b0;
  endtask

  // ab_kind: 0 none, 1 flush, 2 invalidate; pulsed in stall cycle ab_cyc of a miss.
  task automatic fetch(input logic [31:0] pc, input int lat, input int ab_kind,
                       input int ab_cyc, input int hold);
    logic [29:0] t;
    logic [31:0] pa;
    logic [31:0] exp_q[$];
    bit          miss;
    bit          abort;
    int          exp_stall;
    int          c;
    t  = pc[31:2];
    pa = {pc[31:2], 2'b00};
    lat_cfg = lat;
    got_q.delete();
    miss  = (m_find(t) < 0);
    abort = miss && (ab_kind != 0) && (ab_cyc >= 1) && (ab_cyc <= 2 * lat + 3);
    exp_stall = miss ? (abort ? 2 : 1) * (2 * lat + 4) : 0;
    if (miss) begin
      repeat (abort ? 2 : 1) begin
        exp_q.push_back(pa);
        exp_q.push_back(pa + 32'd4);
      end
    end

    @(posedge clk); #1;
    cpu_read = 1'b1;
    cpu_addr = pc;
    c = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      if (c > 200) begin
        chk("stall_bound", 32'(c), 32'(exp_stall));
        break;
      end
      if (miss && ab_kind == 1 && c == ab_cyc) cpu_flush = 1'b1;
      if (miss && ab_kind == 2 && c == ab_cyc) cpu_invalidate = 1'b1;
      @(posedge clk); #1;
      cpu_flush = 1'b0;
      cpu_invalidate = 1'b0;
      c++;
    end

    if (miss) begin
      if (ab_kind == 2) m_clear();
      m_tag[m_ptr] = t;
      m_val[m_ptr] = 1'b1;
      m_ptr = (m_ptr + 1) % N;
    end

    chk("stall_cycles", 32'(c), 32'(exp_stall));
    chk("rdata", cpu_rdata, mem_word(pa));
    chk("rdata_2", cpu_rdata_2, mem_word(pa + 32'd4));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_stall", {31'd0, cpu_stall}, 32'd0);
      chk("hold_rdata", cpu_rdata, mem_word(pa));
    end
    chk("mem_reads", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("mem_addr_seq", got_q[i], exp_q[i]);
    cpu_read = 1'b0;
    #1;
    chk("idle_stall", {31'd0, cpu_stall}, 32'd0);
    chk("idle_rdata", cpu_rdata | cpu_rdata_2, 32'd0);
    $display("txn pc=%h lat=%0d miss=%0d ab_kind=%0d ab_cyc=%0d stall=%0d reads=%0d",
             pc, lat, miss, ab_kind, ab_cyc, c, got_q.size());
  endtask

  task automatic idle_invalidate();
    @(posedge clk); #1;
    cpu_invalidate = 1'b1;
    @(posedge clk); #1;
    cpu_invalidate = 1'b0;
    m_clear();
    $display("txn idle invalidate");
  endtask

  task automatic reset_mid_fetch();
    lat_cfg = 0;
    @(posedge clk); #1;
    cpu_read = 1'b1;
    cpu_addr = 32'h0000_0900;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_rst_mem_read", {31'd0, mem_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    cpu_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    m_ptr = 0;
    got_q.delete();
    $display("txn reset during FETCH2");
  endtask

  initial begin
    logic [31:0] pcs[6];
    logic [31:0] pc;
    int lat;
    int k;
    pcs[0] = 32'h0000_0100; pcs[1] = 32'h0000_0104; pcs[2] = 32'h0000_0200;
    pcs[3] = 32'h0000_0300; pcs[4] = 32'hFFFF_FFFC; pcs[5] = 32'h0000_0000;
    for (int i = 0; i < N; i++) m_val[i] = 1'b0;
    rst = 1'b1;
    cpu_read = 1'b0;
    cpu_addr = '0;
    cpu_flush = 1'b0;
    cpu_invalidate = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_stall", {31'd0, cpu_stall}, 32'd0);
    chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_rdata", cpu_rdata, 32'd0);
    chk("reset_rdata_2", cpu_rdata_2, 32'd0);
    rst = 1'b0;

    fetch(32'hBFC0_0000, 0, 0, 0, 10);
    fetch(32'h8000_0010, 2, 0, 0, 0);
    fetch(32'h0000_0100, 0, 0, 0, 0);
    fetch(32'h0000_0200, 0, 0, 0, 0);
    fetch(32'h0000_0300, 0, 0, 0, 0);
    fetch(32'h0000_0200, 0, 0, 0, 2);
    fetch(32'h0000_0100, 1, 0, 0, 0);
    fetch(32'h0000_0400, 0, 1, 1, 0);
    fetch(32'h0000_0400, 0, 0, 0, 0);
    fetch(32'hFFFF_FFFE, 1, 0, 0, 0);
    idle_invalidate();
    fetch(32'hFFFF_FFFC, 0, 0, 0, 0);
    fetch(32'h0000_0600, 1, 2, 3, 0);
    fetch(32'h0000_0500, 0, 1, 0, 0);
    fetch(32'h0000_0500, 0, 0, 0, 0);
    reset_mid_fetch();
    fetch(32'h0000_0500, 0, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      pc = pcs[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) pc = $urandom;
      pc[1:0] = 2'($urandom);
      lat = $urandom_range(0, 3);
      k = $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) idle_invalidate();
      fetch(pc, lat, (k == 3) ? 2 : (k == 2 ? 1 : 0), $urandom_range(0, 2 * lat + 3),
            $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
